cv32e40p_clic_lite: RTL and testbench

- Parametrised successor to the fixed 32-line core interrupt controller.
- Supports NUM_IRQ lines, each with its own enable, trigger mode (level or rising edge) and priority level.
- Provides pending latches for edge sources, a threshold compare, and an ack handshake with the core controller that clears edge-pending state.
- Sits between the external irq lines and cv32e40p_controller. cv32e40p_cs_registers drives the configuration port and threshold.

---
 rtl/cv32e40p_clic_lite.sv | 136 +++++++++++++
 tb/tb_cv32e40p_clic_lite.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cv32e40p_clic_lite.sv
// Lightweight CLIC for cv32e40p: per-line enable, level/edge trigger and priority.
// The arbitration tree feeds a registered request/id/priority toward the controller.
module cv32e40p_clic_lite #(
  parameter int unsigned NUM_IRQ = 64,
  parameter int unsigned PRIO_W  = 3,
  parameter int unsigned ID_W    = $clog2(NUM_IRQ)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_IRQ-1:0] irq_i,
  input  logic               cfg_we_i,
  input  logic [ID_W-1:0]    cfg_id_i,
  input  logic               cfg_ie_i,
  input  logic               cfg_edge_i,
  input  logic [PRIO_W-1:0]  cfg_prio_i,
  input  logic               cfg_clrpend_i,
  input  logic               m_ie_i,
  input  logic [PRIO_W-1:0]  thresh_i,
  output logic               irq_req_o,
  output logic [ID_W-1:0]    irq_id_o,
  output logic [PRIO_W-1:0]  irq_prio_o,
  input  logic               irq_ack_i,
  input  logic [ID_W-1:0]    irq_ack_id_i,
  output logic               irq_wu_o,
  output logic [NUM_IRQ-1:0] pend_o
);

  localparam int unsigned LEAVES = 1 << ID_W;
  localparam int unsigned NODES  = 2 * LEAVES - 1;

  logic [NUM_IRQ-1:0] irq_q, irq_q2;
  logic [NUM_IRQ-1:0] ie_q, ie_d, edge_q, edge_d, epend_q, epend_d;
  logic [PRIO_W-1:0]  prio_q [NUM_IRQ];
  logic [PRIO_W-1:0]  prio_d [NUM_IRQ];
  logic [NUM_IRQ-1:0] wr_dec, ack_dec, clr, rise, pend, cand;

  logic [LEAVES-1:0]  cand_pad;
  logic [PRIO_W-1:0]  prio_pad [LEAVES];
  logic               node_v   [NODES];
  logic [PRIO_W-1:0]  node_p   [NODES];
  logic [ID_W-1:0]    node_id  [NODES];
  logic               win_valid;
  logic [PRIO_W-1:0]  win_prio;
  logic [ID_W-1:0]    win_id;

  logic               irq_req_q;
  logic [ID_W-1:0]    irq_id_q;
  logic [PRIO_W-1:0]  irq_prio_q;

  // One-hot decodes; ids at or beyond NUM_IRQ shift out and select nothing.
  assign wr_dec  = cfg_we_i  ? (NUM_IRQ'(1) << cfg_id_i)     : '0;
  assign ack_dec = irq_ack_i ? (NUM_IRQ'(1) << irq_ack_id_i) : '0;
  assign clr     = ack_dec | (wr_dec & {NUM_IRQ{cfg_clrpend_i}});

  assign ie_d    = (ie_q   & ~wr_dec) | (wr_dec & {NUM_IRQ{cfg_ie_i}});
  assign edge_d  = (edge_q & ~wr_dec) | (wr_dec & {NUM_IRQ{cfg_edge_i}});
  assign rise    = irq_q & ~irq_q2;

  // Latched pending only survives while the line stays in edge mode; set beats clear.
  assign epend_d = edge_d & edge_q & (rise | (epend_q & ~clr));
  assign pend    = (edge_q & (epend_q | rise)) | (~edge_q & irq_q);

  // Arbitrate on post-edge config and pending so a config write or an ack
  // is reflected in the registered outputs one cycle later, never stale.
  assign cand    = ((edge_d & epend_d) | (~edge_d & irq_q)) & ie_d;

  assign irq_wu_o = |(irq_i & ie_q) | |(pend & ie_q & edge_q);
  assign pend_o   = pend;

  always_comb begin
    for (int unsigned i = 0; i < NUM_IRQ; i++) begin
      prio_d[i] = wr_dec[i] ? cfg_prio_i : prio_q[i];
    end
  end

  always_comb begin
    cand_pad = LEAVES'(cand);
    for (int unsigned i = 0; i < LEAVES; i++) begin
      prio_pad[i] = '0;
    end
    for (int unsigned i = 0; i < NUM_IRQ; i++) begin
      prio_pad[i] = prio_d[i];
    end
    for (int unsigned i = 0; i < LEAVES; i++) begin
      node_v [LEAVES-1+i] = cand_pad[i];
      node_p [LEAVES-1+i] = cand_pad[i] ? prio_pad[i] : '0;
      node_id[LEAVES-1+i] = cand_pad[i] ? ID_W'(i)    : '0;
    end
    // Heap-ordered tree: right child holds higher ids, so it wins ties.
    for (int unsigned k = LEAVES - 1; k > 0; k--) begin
      if (node_v[2*k] && (!node_v[2*k-1] || node_p[2*k] >= node_p[2*k-1])) begin
        node_v [k-1] = node_v [2*k];
        node_p [k-1] = node_p [2*k];
        node_id[k-1] = node_id[2*k];
      end else begin
        node_v [k-1] = node_v [2*k-1];
        node_p [k-1] = node_p [2*k-1];
        node_id[k-1] = node_id[2*k-1];
      end
    end
    win_valid = node_v[0];
    win_prio  = node_p[0];
    win_id    = node_id[0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_q      <= '0;
      irq_q2     <= '0;
      ie_q       <= '0;
      edge_q     <= '0;
      epend_q    <= '0;
      for (int unsigned i = 0; i < NUM_IRQ; i++) begin
        prio_q[i] <= '0;
      end
      irq_req_q  <= 1'b0;
      irq_id_q   <= '0;
      irq_prio_q <= '0;
    end else begin
      irq_q      <= irq_i;
      irq_q2     <= irq_q;
      ie_q       <= ie_d;
      edge_q     <= edge_d;
      epend_q    <= epend_d;
      prio_q     <= prio_d;
      irq_req_q  <= win_valid & m_ie_i & (win_prio > thresh_i);
      irq_id_q   <= win_id;
      irq_prio_q <= win_prio;
    end
  end

  assign irq_req_o  = irq_req_q;
  assign irq_id_o   = irq_id_q;
  assign irq_prio_o = irq_prio_q;

endmodule

// File: tb/tb_cv32e40p_clic_lite.sv
// Directed bench for cv32e40p_clic_lite: vector table plus hand-written multi-cycle sequences.
// Built with 48 lines so that out-of-range configuration ids fit in the 6-bit id port.
module tb_cv32e40p_clic_lite;

  localparam int unsigned N  = 48;
  localparam int unsigned PW = 3;
  localparam int unsigned IW = 6;

  logic          clk = 1'b0;
  logic          clk_en = 1'b1;
  logic          rst_n;
  logic [N-1:0]  irq_i;
  logic          cfg_we_i, cfg_ie_i, cfg_edge_i, cfg_clrpend_i;
  logic [IW-1:0] cfg_id_i;
  logic [PW-1:0] cfg_prio_i;
  logic          m_ie_i;
  logic [PW-1:0] thresh_i;
  logic          irq_req_o;
  logic [IW-1:0] irq_id_o;
  logic [PW-1:0] irq_prio_o;
  logic          irq_ack_i;
  logic [IW-1:0] irq_ack_id_i;
  logic          irq_wu_o;
  logic [N-1:0]  pend_o;

  always #5 if (clk_en) clk = ~clk;

  cv32e40p_clic_lite #(.NUM_IRQ(N), .PRIO_W(PW), .ID_W(IW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .irq_i        (irq_i),
    .cfg_we_i     (cfg_we_i),
    .cfg_id_i     (cfg_id_i),
    .cfg_ie_i     (cfg_ie_i),
    .cfg_edge_i   (cfg_edge_i),
    .cfg_prio_i   (cfg_prio_i),
    .cfg_clrpend_i(cfg_clrpend_i),
    .m_ie_i       (m_ie_i),
    .thresh_i     (thresh_i),
    .irq_req_o    (irq_req_o),
    .irq_id_o     (irq_id_o),
    .irq_prio_o   (irq_prio_o),
    .irq_ack_i    (irq_ack_i),
    .irq_ack_id_i (irq_ack_id_i),
    .irq_wu_o     (irq_wu_o),
    .pend_o       (pend_o)
  );

  typedef struct {
    logic [N-1:0]  irq;
    logic          we;
    logic [IW-1:0] id;
    logic          ie;
    logic          edg;
    logic [PW-1:0] prio;
    logic          clrp;
    logic          mie;
    logic [PW-1:0] th;
    logic          ack;
    logic [IW-1:0] aid;
    logic          ereq;
    logic [IW-1:0] eid;
    logic [PW-1:0] eprio;
    logic [N-1:0]  epend;
  } vec_t;

  vec_t tbl[$];
  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  function automatic logic [N-1:0] b(input int unsigned n);
    logic [N-1:0] v;
    v = '0;
    v[n] = 1'b1;
    return v;
  endfunction

  function automatic vec_t mk(input logic [N-1:0] irq,
                              input int unsigned we, input int unsigned id, input int unsigned ie,
                              input int unsigned edg, input int unsigned pr, input int unsigned clrp,
                              input int unsigned mie, input int unsigned th,
                              input int unsigned ack, input int unsigned aid,
                              input int unsigned ereq, input int unsigned eid, input int unsigned epr,
                              input logic [N-1:0] epend);
    vec_t v;
    v.irq = irq;       v.we = (we != 0);   v.id = IW'(id);     v.ie = (ie != 0);
    v.edg = (edg != 0); v.prio = PW'(pr);  v.clrp = (clrp != 0);
    v.mie = (mie != 0); v.th = PW'(th);    v.ack = (ack != 0); v.aid = IW'(aid);
    v.ereq = (ereq != 0); v.eid = IW'(eid); v.eprio = PW'(epr); v.epend = epend;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg(input int unsigned id, input logic ie, input logic edg,
                     input int unsigned pr, input logic clrp);
    cfg_we_i = 1'b1; cfg_id_i = IW'(id); cfg_ie_i = ie; cfg_edge_i = edg;
    cfg_prio_i = PW'(pr); cfg_clrpend_i = clrp;
    step();
    cfg_we_i = 1'b0; cfg_clrpend_i = 1'b0;
  endtask

  task automatic ack(input int unsigned id);
    irq_ack_i = 1'b1; irq_ack_id_i = IW'(id);
    step();
    irq_ack_i = 1'b0;
  endtask

  task automatic chk_out(input string nm, input logic req, input int unsigned id, input int unsigned pr);
    chk({nm, ".req"},  64'(irq_req_o),  64'(req));
    chk({nm, ".id"},   64'(irq_id_o),   64'(id));
    chk({nm, ".prio"}, 64'(irq_prio_o), 64'(pr));
  endtask

  initial begin
    rst_n = 1'b0; irq_i = '0; cfg_we_i = 1'b0; cfg_id_i = '0; cfg_ie_i = 1'b0; cfg_edge_i = 1'b0;
    cfg_prio_i = '0; cfg_clrpend_i = 1'b0; m_ie_i = 1'b0; thresh_i = '0;
    irq_ack_i = 1'b0; irq_ack_id_i = '0;

    //        irq          we id ie ed pr cp mie th ack aid  req id pr  pend
    tbl.push_back(mk('0,         1, 5, 1, 0, 3, 0, 1, 0, 0, 0,  0, 0, 0, '0));
    tbl.push_back(mk(b(5),       0, 0, 0, 0, 0, 0, 1, 0, 0, 0,  0, 0, 0, b(5)));
    tbl.push_back(mk(b(5),       0, 0, 0, 0, 0, 0, 1, 0, 0, 0,  1, 5, 3, b(5)));
    tbl.push_back(mk('0,         0, 0, 0, 0, 0, 0, 1, 0, 0, 0,  1, 5, 3, '0));
    tbl.push_back(mk('0,         0, 0, 0, 0, 0, 0, 1, 0, 0, 0,  0, 0, 0, '0));
    tbl.push_back(mk('0,         1, 5, 0, 0, 0, 0, 1, 0, 0, 0,  0, 0, 0, '0));
    tbl.push_back(mk('0,         1,10, 1, 1, 2, 0, 1, 0, 0, 0,  0, 0, 0, '0));
    tbl.push_back(mk('0,         1,20, 1, 1, 2, 0, 1, 0, 0, 0,  0, 0, 0, '0));
    tbl.push_back(mk(b(10)|b(20),0, 0, 0, 0, 0, 0, 1, 0, 0, 0,  0, 0, 0, b(10)|b(20)));
    tbl.push_back(mk('0,         0, 0, 0, 0, 0, 0, 1, 0, 0, 0,  1,20, 2, b(10)|b(20)));
    tbl.push_back(mk('0,         0, 0, 0, 0, 0, 0, 1, 0, 1,20,  1,10, 2, b(10)));
    tbl.push_back(mk('0,         0, 0, 0, 0, 0, 0, 1, 0, 1,10,  0, 0, 0, '0));
    tbl.push_back(mk('0,         1, 7, 1, 0, 1, 0, 1, 0, 0, 0,  0, 0, 0, '0));
    tbl.push_back(mk('0,         1, 3, 1, 0, 6, 0, 1, 0, 0, 0,  0, 0, 0, '0));
    tbl.push_back(mk(b(3)|b(7),  0, 0, 0, 0, 0, 0, 1, 0, 0, 0,  0, 0, 0, b(3)|b(7)));
    tbl.push_back(mk(b(3)|b(7),  0, 0, 0, 0, 0, 0, 1, 0, 0, 0,  1, 3, 6, b(3)|b(7)));
    tbl.push_back(mk(b(3)|b(7),  0, 0, 0, 0, 0, 0, 1, 6, 0, 0,  0, 3, 6, b(3)|b(7)));
    tbl.push_back(mk(b(3)|b(7),  0, 0, 0, 0, 0, 0, 1, 5, 0, 0,  1, 3, 6, b(3)|b(7)));
    tbl.push_back(mk(b(3)|b(7),  0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 3, 6, b(3)|b(7)));
    tbl.push_back(mk(b(3)|b(7),  0, 0, 0, 0, 0, 0, 1, 0, 0, 0,  1, 3, 6, b(3)|b(7)));
    tbl.push_back(mk(b(3)|b(7),  1, 3, 1, 0, 1, 0, 1, 0, 0, 0,  1, 7, 1, b(3)|b(7)));
    tbl.push_back(mk(b(3)|b(7),  1, 7, 1, 0, 0, 0, 1, 0, 0, 0,  1, 3, 1, b(3)|b(7)));
    tbl.push_back(mk(b(3)|b(7),  1, 3, 1, 0, 0, 0, 1, 0, 0, 0,  0, 7, 0, b(3)|b(7)));
    tbl.push_back(mk('0,         0, 0, 0, 0, 0, 0, 1, 0, 0, 0,  0, 7, 0, '0));
    tbl.push_back(mk('0,         0, 0, 0, 0, 0, 0, 1, 0, 0, 0,  0, 0, 0, '0));

    step();
    step();
    chk_out("reset", 1'b0, 0, 0);
    chk("reset.pend", 64'(pend_o), 64'(0));
    chk("reset.wu",   64'(irq_wu_o), 64'(0));
    rst_n = 1'b1;
    m_ie_i = 1'b1;

    foreach (tbl[k]) begin
      irq_i = tbl[k].irq; cfg_we_i = tbl[k].we; cfg_id_i = tbl[k].id; cfg_ie_i = tbl[k].ie;
      cfg_edge_i = tbl[k].edg; cfg_prio_i = tbl[k].prio; cfg_clrpend_i = tbl[k].clrp;
      m_ie_i = tbl[k].mie; thresh_i = tbl[k].th; irq_ack_i = tbl[k].ack; irq_ack_id_i = tbl[k].aid;
      step();
      chk_out($sformatf("row%0d", k), tbl[k].ereq, int'(tbl[k].eid), int'(tbl[k].eprio));
      chk($sformatf("row%0d.pend", k), 64'(pend_o), 64'(tbl[k].epend));
    end
    cfg_we_i = 1'b0; cfg_clrpend_i = 1'b0; irq_ack_i = 1'b0; m_ie_i = 1'b1; thresh_i = '0;

    // Edge line 12: a fresh rising edge coinciding with its ack keeps it pending.
    cfg(12, 1'b1, 1'b1, 4, 1'b0);
    irq_i = b(12); step();
    chk("e12.rise_pend", 64'(pend_o), 64'(b(12)));
    chk("e12.rise_req",  64'(irq_req_o), 64'(0));
    irq_i = '0; step();
    chk_out("e12.req", 1'b1, 12, 4);
    irq_i = b(12); step();
    ack(12);
    chk("e12.ack_vs_edge.pend", 64'(pend_o[12]), 64'(1));
    chk_out("e12.ack_vs_edge", 1'b1, 12, 4);
    ack(12);
    chk("e12.acked.pend", 64'(pend_o), 64'(0));
    chk_out("e12.acked", 1'b0, 0, 0);

    // Re-latch line 12, then out-of-range config writes must change nothing.
    irq_i = '0; step();
    irq_i = b(12); step();
    irq_i = '0; step();
    chk("e12.relatch.pend", 64'(pend_o), 64'(b(12)));
    cfg(48, 1'b0, 1'b0, 0, 1'b1);
    chk_out("oor48", 1'b1, 12, 4);
    chk("oor48.pend", 64'(pend_o), 64'(b(12)));
    cfg(63, 1'b0, 1'b0, 0, 1'b1);
    chk_out("oor63", 1'b1, 12, 4);
    chk("oor63.pend", 64'(pend_o), 64'(b(12)));

    // Edge -> level discards the latch; level -> edge starts clear.
    cfg(12, 1'b1, 1'b0, 4, 1'b0);
    chk_out("e12.to_level", 1'b0, 0, 0);
    chk("e12.to_level.pend", 64'(pend_o), 64'(0));
    cfg(12, 1'b1, 1'b1, 4, 1'b0);
    chk("e12.to_edge.pend", 64'(pend_o), 64'(0));
    chk("e12.to_edge.req",  64'(irq_req_o), 64'(0));

    // Pending cleared by a config write with clrpend.
    irq_i = b(12); step();
    irq_i = '0; step();
    chk_out("e12.pre_clr", 1'b1, 12, 4);
    cfg(12, 1'b1, 1'b1, 4, 1'b1);
    chk("e12.clrpend.pend", 64'(pend_o), 64'(0));
    chk_out("e12.clrpend", 1'b0, 0, 0);

    // Wake-up with the clock stopped.
    cfg(1, 1'b1, 1'b0, 2, 1'b0);
    clk_en = 1'b0;
    #20;
    chk("wu.idle", 64'(irq_wu_o), 64'(0));
    irq_i = b(1);
    #1;
    chk("wu.raise", 64'(irq_wu_o), 64'(1));
    #20;
    chk("wu.no_clock_req", 64'(irq_req_o), 64'(0));
    clk_en = 1'b1;
    step();
    step();
    chk_out("l1.req", 1'b1, 1, 2);

    // Asynchronous reset mid-request.
    #1;
    rst_n = 1'b0;
    #1;
    chk_out("async_rst", 1'b0, 0, 0);
    chk("async_rst.pend", 64'(pend_o), 64'(0));
    chk("async_rst.wu",   64'(irq_wu_o), 64'(0));
    step();
    chk_out("rst_held", 1'b0, 0, 0);
    rst_n = 1'b1;
    irq_i = '0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
